// File: rtl/aes_pkg.sv
// Shared AES constants, FSM encoding and GF(2^8) helper for the round datapath.
package aes_pkg;

    localparam logic [7:0] AES_POLY = 8'h1b;
    localparam int unsigned STATE_W = 128;
    localparam int unsigned COL_W   = 32;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } mix_state_e;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/mix_columns_seq_if.sv
// Valid/ready handshake bundle for the MixColumns stage: state in, transformed state out.
interface mix_columns_seq_if;
    import aes_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic               in_inv;
    logic [STATE_W-1:0] in_data;
    logic               out_valid;
    logic               out_ready;
    logic [STATE_W-1:0] out_data;

    modport slave (
        input  in_valid, in_inv, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

    modport master (
        output in_valid, in_inv, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );
endinterface

// File: rtl/mix_column_word.sv
// Combinational MixColumns / InvMixColumns on one 32-bit column, row 0 in the MSB byte.
module mix_column_word
    import aes_pkg::*;
(
    input  logic [COL_W-1:0] i_col,
    input  logic             i_inv,
    output logic [COL_W-1:0] o_col
);

    logic [7:0] w_a[4];
    logic [7:0] w_x2[4];
    logic [7:0] w_x4[4];
    logic [7:0] w_x8[4];
    logic [7:0] w_m3[4];
    logic [7:0] w_m9[4];
    logic [7:0] w_m11[4];
    logic [7:0] w_m13[4];
    logic [7:0] w_m14[4];

    always_comb begin
        for (int r = 0; r < 4; r++) begin
            w_a[r]   = i_col[COL_W-1-8*r -: 8];
            w_x2[r]  = xtime(w_a[r]);
            w_x4[r]  = xtime(w_x2[r]);
            w_x8[r]  = xtime(w_x4[r]);
            w_m3[r]  = w_x2[r] ^ w_a[r];
            w_m9[r]  = w_x8[r] ^ w_a[r];
            w_m11[r] = w_x8[r] ^ w_x2[r] ^ w_a[r];
            w_m13[r] = w_x8[r] ^ w_x4[r] ^ w_a[r];
            w_m14[r] = w_x8[r] ^ w_x4[r] ^ w_x2[r];
        end

        if (i_inv) begin
            o_col = {w_m14[0] ^ w_m11[1] ^ w_m13[2] ^ w_m9[3],
                     w_m9[0]  ^ w_m14[1] ^ w_m11[2] ^ w_m13[3],
                     w_m13[0] ^ w_m9[1]  ^ w_m14[2] ^ w_m11[3],
                     w_m11[0] ^ w_m13[1] ^ w_m9[2]  ^ w_m14[3]};
        end else begin
            o_col = {w_x2[0] ^ w_m3[1] ^ w_a[2]  ^ w_a[3],
                     w_a[0]  ^ w_x2[1] ^ w_m3[2] ^ w_a[3],
                     w_a[0]  ^ w_a[1]  ^ w_x2[2] ^ w_m3[3],
                     w_m3[0] ^ w_a[1]  ^ w_a[2]  ^ w_x2[3]};
        end
    end

endmodule

// File: rtl/mix_columns_seq.sv
// Sequential MixColumns stage: one shared column transform walks the four columns of a state.
module mix_columns_seq
    import aes_pkg::*;
#(
    parameter int unsigned NUM_COLS = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    mix_columns_seq_if.slave  bus,
    output logic              busy
);

    localparam int unsigned CNT_W  = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
    localparam int unsigned BASE_W = $clog2(STATE_W);

    mix_state_e         r_state;
    logic [CNT_W-1:0]   r_col_cnt;
    logic [STATE_W-1:0] r_work;
    logic [STATE_W-1:0] r_out;
    logic               r_inv;
    logic               r_valid;

    logic [BASE_W-1:0]  w_base;
    logic [COL_W-1:0]   w_col;
    logic [COL_W-1:0]   w_mixed;

    // Column 0 sits in the top 32 bits, so the slice base counts down with col_cnt.
    assign w_base = BASE_W'(COL_W * (NUM_COLS - 1 - int'(r_col_cnt)));
    assign w_col  = r_work[w_base +: COL_W];

    mix_column_word u_mix_column_word (
        .i_col (w_col),
        .i_inv (r_inv),
        .o_col (w_mixed)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= StIdle;
            r_col_cnt <= '0;
            r_work    <= '0;
            r_out     <= '0;
            r_inv     <= 1'b0;
            r_valid   <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (bus.in_valid) begin
                        r_work    <= bus.in_data;
                        r_inv     <= bus.in_inv;
                        r_col_cnt <= '0;
                        r_state   <= StBusy;
                    end
                end
                StBusy: begin
                    r_out[w_base +: COL_W] <= w_mixed;
                    r_col_cnt              <= r_col_cnt + CNT_W'(1);
                    if (r_col_cnt == CNT_W'(NUM_COLS - 1)) begin
                        r_state <= StDone;
                        r_valid <= 1'b1;
                    end
                end
                StDone: begin
                    if (bus.out_ready) begin
                        r_valid <= 1'b0;
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == StIdle);
    assign bus.out_valid = r_valid;
    assign bus.out_data  = r_out;
    assign busy          = (r_state != StIdle);

endmodule

// File: tb/tb_mix_columns_seq.sv
// Self-checking bench for mix_columns_seq against a matrix-multiply GF(2^8) reference model.
module tb_mix_columns_seq;

    localparam logic [127:0] FWD_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] FWD_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] INV_IN  = 128'h8e4da1bc_9fdc589d_4d7ebdf8_d5d5d7d6;
    localparam logic [127:0] INV_OUT = 128'hdb135345_f20a225c_2d26314c_d4d4d4d5;
    localparam logic [127:0] ONES    = 128'h01010101_01010101_01010101_01010101;

    logic clk;
    logic rst_n;
    logic busy;
    int   n_vec;
    int   n_err;

    mix_columns_seq_if bus ();

    mix_columns_seq #(.NUM_COLS(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Peasant multiply modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    // Circulant matrix product; row r uses coefficient coef[(k - r) mod 4] for byte k.
    function automatic logic [127:0] model(input logic [127:0] s, input logic inv);
        logic [7:0]   coef[4];
        logic [7:0]   a[4];
        logic [7:0]   acc;
        logic [127:0] res = '0;
        if (inv) coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        else     coef = '{8'h02, 8'h03, 8'h01, 8'h01};
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < 4; k++) a[k] = s[127 - 32*c - 8*k -: 8];
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++) acc = acc ^ gmul(coef[(k - r + 4) % 4], a[k]);
                res[127 - 32*c - 8*r -: 8] = acc;
            end
        end
        return res;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Wait for IDLE, present one state, then wait for out_valid (out_ready left low).
    task automatic send(input logic [127:0] d, input logic inv, output int lat, output bit ok);
        ok  = 1'b0;
        lat = 0;
        for (int i = 0; i < 20 && !bus.in_ready; i++) begin
            @(posedge clk); #1;
        end
        if (!bus.in_ready) return;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_inv   = inv;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        for (int i = 0; i < 20 && !bus.out_valid; i++) begin
            @(posedge clk); #1;
            lat++;
        end
        ok = bus.out_valid;
    endtask

    task automatic drain();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if ({bus.in_ready, bus.out_valid, busy} !== 3'b100) begin
            n_err++;
            $display("FAIL reset_flags: got rdy/vld/busy=%b want 100",
                     {bus.in_ready, bus.out_valid, busy});
        end
        n_vec++;
        if (bus.out_data !== '0) begin
            n_err++;
            $display("FAIL reset_data: got %h want 0", bus.out_data);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_directed(input logic [127:0] d, input logic inv, input logic [127:0] exp);
        int lat;
        bit ok;
        send(d, inv, lat, ok);
        n_vec++;
        if (!ok || lat !== 4) begin
            n_err++;
            $display("FAIL directed_latency inv=%0b: got ok=%0b lat=%0d want lat=4", inv, ok, lat);
        end
        n_vec++;
        if (bus.out_data !== exp) begin
            n_err++;
            $display("FAIL directed_data inv=%0b: got %h want %h", inv, bus.out_data, exp);
        end
        drain();
        n_vec++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_data !== exp) begin
            n_err++;
            $display("FAIL directed_handshake: got vld=%b rdy=%b data=%h want 0/1/%h",
                     bus.out_valid, bus.in_ready, bus.out_data, exp);
        end
    endtask

    task automatic test_random();
        logic [127:0] d;
        logic         inv;
        int           lat;
        bit           ok;
        for (int n = 0; n < 24; n++) begin
            d   = rand128();
            inv = 1'($urandom_range(0, 1));
            send(d, inv, lat, ok);
            n_vec++;
            if (!ok || bus.out_data !== model(d, inv)) begin
                n_err++;
                $display("FAIL random[%0d] inv=%0b: got %h want %h",
                         n, inv, bus.out_data, model(d, inv));
            end
            drain();
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] exp;
        int           lat;
        bit           ok;
        exp = model(FWD_IN, 1'b0);
        send(FWD_IN, 1'b0, lat, ok);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            n_vec++;
            if ({bus.out_valid, bus.in_ready, busy} !== 3'b101 || bus.out_data !== exp) begin
                n_err++;
                $display("FAIL backpressure[%0d]: got vld/rdy/busy=%b data=%h want 101 %h",
                         i, {bus.out_valid, bus.in_ready, busy}, bus.out_data, exp);
            end
        end
        drain();
        n_vec++;
        if ({bus.out_valid, bus.in_ready, busy} !== 3'b010 || bus.out_data !== exp) begin
            n_err++;
            $display("FAIL backpressure_release: got vld/rdy/busy=%b data=%h want 010 %h",
                     {bus.out_valid, bus.in_ready, busy}, bus.out_data, exp);
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] outs[$];
        int           hs_cyc[$];
        int           acc_cyc[$];
        bit           acc;
        bit           hs;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = FWD_IN;
        bus.in_inv    = 1'b0;
        for (int cyc = 0; cyc < 40 && outs.size() < 2; cyc++) begin
            acc = bus.in_valid && bus.in_ready;
            hs  = bus.out_valid && bus.out_ready;
            if (hs) begin
                outs.push_back(bus.out_data);
                hs_cyc.push_back(cyc);
            end
            if (acc) acc_cyc.push_back(cyc);
            @(posedge clk); #1;
            if (acc && acc_cyc.size() == 1) begin
                bus.in_data = INV_IN;
                bus.in_inv  = 1'b1;
            end else if (acc) begin
                bus.in_valid = 1'b0;
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        n_vec++;
        if (outs.size() != 2 || acc_cyc.size() != 2) begin
            n_err++;
            $display("FAIL b2b_count: got outs=%0d accepts=%0d want 2/2",
                     outs.size(), acc_cyc.size());
        end else begin
            n_vec++;
            if (outs[0] !== FWD_OUT) begin
                n_err++;
                $display("FAIL b2b_first: got %h want %h", outs[0], FWD_OUT);
            end
            n_vec++;
            if (outs[1] !== INV_OUT) begin
                n_err++;
                $display("FAIL b2b_second: got %h want %h", outs[1], INV_OUT);
            end
            n_vec++;
            if (acc_cyc[1] != hs_cyc[0] + 1) begin
                n_err++;
                $display("FAIL b2b_accept_cycle: got %0d want %0d", acc_cyc[1], hs_cyc[0] + 1);
            end
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        bit ok;
        bus.in_valid = 1'b1;
        bus.in_data  = FWD_IN;
        bus.in_inv   = 1'b0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #4;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({bus.out_valid, bus.in_ready, busy} !== 3'b010 || bus.out_data !== '0) begin
            n_err++;
            $display("FAIL reset_mid: got vld/rdy/busy=%b data=%h want 010 0",
                     {bus.out_valid, bus.in_ready, busy}, bus.out_data);
        end
        #2;
        rst_n = 1'b1;
        send(ONES, 1'b0, lat, ok);
        n_vec++;
        if (!ok || bus.out_data !== ONES) begin
            n_err++;
            $display("FAIL reset_mid_recover: got %h want %h", bus.out_data, ONES);
        end
        drain();
    endtask

    task automatic test_mode_isolation();
        logic [127:0] d;
        logic         inv;
        for (int n = 0; n < 6; n++) begin
            d   = rand128();
            inv = 1'(n % 2);
            bus.in_valid = 1'b1;
            bus.in_data  = d;
            bus.in_inv   = inv;
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            for (int i = 0; i < 8 && !bus.out_valid; i++) begin
                bus.in_inv  = ~bus.in_inv;
                bus.in_data = rand128();
                @(posedge clk); #1;
            end
            n_vec++;
            if (!bus.out_valid || bus.out_data !== model(d, inv)) begin
                n_err++;
                $display("FAIL mode_isolation[%0d] inv=%0b: got vld=%b %h want %h",
                         n, inv, bus.out_valid, bus.out_data, model(d, inv));
            end
            drain();
        end
    endtask

    initial begin
        n_vec         = 0;
        n_err         = 0;
        bus.in_valid  = 1'b0;
        bus.in_inv    = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_directed(FWD_IN, 1'b0, FWD_OUT);
        test_directed(INV_IN, 1'b1, INV_OUT);
        test_random();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_mode_isolation();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
